// File: rtl/strip_trigger_queue_pkg.sv
// Shared types and constants for the strip trigger queue: FSM encoding,
// the "no band" marker and the packed band/BCID trigger entry.
package strip_trigger_queue_pkg;

  localparam int BAND_W  = 8;
  localparam int BCID_W  = 12;
  localparam int ENTRY_W = BAND_W + BCID_W;
  localparam int COUNT_W = 5;

  localparam logic [BAND_W-1:0] NO_BAND = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } trig_state_e;

  typedef struct packed {
    logic [BAND_W-1:0] band_id;
    logic [BCID_W-1:0] bcid;
  } trig_entry_t;

  function automatic trig_entry_t make_entry(input logic [BAND_W-1:0] band,
                                             input logic [BCID_W-1:0] bc);
    trig_entry_t e;
    e.band_id = band;
    e.bcid    = bc;
    return e;
  endfunction

endpackage

// File: rtl/trig_entry_fifo.sv
// First-word fall-through trigger-entry FIFO: asynchronous-read distributed
// RAM, power-of-two depth so the pointers wrap on their own.
module trig_entry_fifo
  import strip_trigger_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  trig_entry_t        wdata,
  output trig_entry_t        rdata,
  output logic               empty,
  output logic               full,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [COUNT_W-1:0] count_r;
  logic               empty_s;
  logic               full_s;
  logic               rd_s;
  logic               wr_s;

  // Occupancy flags and qualified read/write enables
  always_comb begin
    empty_s = (count_r == {COUNT_W{1'b0}});
    full_s  = (count_r == COUNT_W'(DEPTH));
    rd_s    = pop && !empty_s;
    wr_s    = push && (!full_s || rd_s);
  end

  // Storage array; no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers and exact occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {COUNT_W{1'b0}};
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + PTR_W'(1'b1);
      end
      if (rd_s) begin
        rptr_r <= rptr_r + PTR_W'(1'b1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + COUNT_W'(1'b1);
        2'b01:   count_r <= count_r - COUNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = trig_entry_t'(mem_r[rptr_r]);
  assign empty = empty_s;
  assign full  = full_s;
  assign count = count_r;

endmodule

// File: rtl/strip_trigger_queue.sv
// Queues band/BCID trigger words and hands them to the serializer on
// 160M slot boundaries, with duplicate filtering and overflow accounting.
module strip_trigger_queue
  import strip_trigger_queue_pkg::*;
#(
  parameter int DEPTH            = 8,
  parameter int SLOT_PERIOD_LOG2 = 2,
  parameter int ACK_TIMEOUT      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ready,
  input  logic [7:0]  band_id,
  input  logic [11:0] bcid,
  input  logic        gen_ready,
  output logic        load_out,
  output logic [11:0] bcid_out,
  output logic [7:0]  band_id_out,
  output logic [4:0]  fifo_count,
  output logic [15:0] drop_count,
  output logic        overflow
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 32'sd1);

  trig_state_e                 state_r;
  trig_state_e                 state_nxt_s;
  logic [ACK_W-1:0]            ack_timer_r;
  logic [SLOT_PERIOD_LOG2-1:0] slot_cnt_r;
  logic                        slot_hit_s;
  trig_entry_t                 last_pair_r;
  trig_entry_t                 in_entry_s;
  trig_entry_t                 fifo_rdata_s;
  logic                        fifo_empty_s;
  logic                        fifo_full_s;
  logic                        push_req_s;
  logic                        pop_s;
  logic                        wr_en_s;
  logic                        drop_s;
  logic                        load_out_r;
  logic [BCID_W-1:0]           bcid_out_r;
  logic [BAND_W-1:0]           band_id_out_r;
  logic [15:0]                 drop_count_r;
  logic                        overflow_r;

  // Push filtering, pop decision and overflow detection
  always_comb begin
    slot_hit_s = &slot_cnt_r;
    in_entry_s = make_entry(band_id, bcid);
    push_req_s = data_ready && (band_id != NO_BAND) && (in_entry_s != last_pair_r);
    pop_s      = (state_r == ST_IDLE) && slot_hit_s && !fifo_empty_s && gen_ready;
    wr_en_s    = push_req_s && (!fifo_full_s || pop_s);
    drop_s     = push_req_s && fifo_full_s && !pop_s;
  end

  trig_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en_s),
    .pop   (pop_s),
    .wdata (in_entry_s),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count)
  );

  // Load handshake next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!gen_ready)                  state_nxt_s = ST_WAIT_DONE;
        else if (ack_timer_r == ACK_LAST) state_nxt_s = ST_IDLE;
        else                             state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_DONE: begin
        if (gen_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_WAIT_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and acknowledge timeout timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ack_timer_r <= {ACK_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WAIT_ACK) ack_timer_r <= ack_timer_r + ACK_W'(1'b1);
      else                        ack_timer_r <= {ACK_W{1'b0}};
    end
  end

  // Free-running slot counter and duplicate-compare register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_r  <= {SLOT_PERIOD_LOG2{1'b0}};
      last_pair_r <= make_entry(NO_BAND, 12'h000);
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_PERIOD_LOG2'(1'b1);
      if (push_req_s) begin
        last_pair_r <= in_entry_s;
      end
    end
  end

  // Serializer load strobe and held entry; the popped head is captured
  // on the IDLE->LOAD edge so it is visible together with load_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_out_r    <= 1'b0;
      bcid_out_r    <= {BCID_W{1'b0}};
      band_id_out_r <= {BAND_W{1'b0}};
    end else begin
      load_out_r <= pop_s;
      if (pop_s) begin
        bcid_out_r    <= fifo_rdata_s.bcid;
        band_id_out_r <= fifo_rdata_s.band_id;
      end
    end
  end

  // Overflow accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_r <= 16'h0000;
      overflow_r   <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_count_r != 16'hFFFF) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
    end
  end

  assign load_out    = load_out_r;
  assign bcid_out    = bcid_out_r;
  assign band_id_out = band_id_out_r;
  assign drop_count  = drop_count_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_strip_trigger_queue.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_strip_trigger_queue;

  localparam int DEPTH = 8;
  localparam int SLOT_LOG2 = 2;
  localparam int ACK = 8;
  localparam int SLOTS = 1 << SLOT_LOG2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_ready = 1'b0;
  logic [7:0]  band_id = 8'hFF;
  logic [11:0] bcid = 12'h000;
  logic        gen_ready = 1'b1;
  logic        load_out;
  logic [11:0] bcid_out;
  logic [7:0]  band_id_out;
  logic [4:0]  fifo_count;
  logic [15:0] drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  strip_trigger_queue #(
    .DEPTH(DEPTH), .SLOT_PERIOD_LOG2(SLOT_LOG2), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .band_id(band_id),
    .bcid(bcid), .gen_ready(gen_ready), .load_out(load_out),
    .bcid_out(bcid_out), .band_id_out(band_id_out), .fifo_count(fifo_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: trigger queue plus serializer-handshake bookkeeping
  logic [19:0] m_q[$];
  logic [19:0] m_last;
  int          m_drops;
  bit          m_ovf;
  int          m_n;
  bit          m_free;
  bit          m_low;
  int          m_load_cyc;
  int          m_deadline;
  bit          e_load;
  logic [7:0]  e_band;
  logic [11:0] e_bcid;

  task automatic model_step();
    logic [19:0] pair;
    logic [19:0] head;
    bit slot_hit, pop, req;
    if (reset) begin
      m_q.delete();
      m_last = {8'hFF, 12'h000};
      m_drops = 0; m_ovf = 1'b0; m_n = 0; m_free = 1'b1; m_low = 1'b0;
      e_load = 1'b0; e_band = 8'h00; e_bcid = 12'h000;
      return;
    end
    slot_hit = ((m_n % SLOTS) == SLOTS - 1);
    m_n++;
    pop = m_free && slot_hit && (m_q.size() > 0) && gen_ready;
    // serializer handshake after a load: wait for low within ACK cycles, then high
    if (!m_free && cyc > m_load_cyc) begin
      if (!m_low) begin
        if (!gen_ready) m_low = 1'b1;
        else if (cyc == m_deadline) m_free = 1'b1;
      end else if (gen_ready) begin
        m_free = 1'b1;
      end
    end
    e_load = pop;
    if (pop) begin
      head = m_q.pop_front();
      e_band = head[19:12];
      e_bcid = head[11:0];
      m_free = 1'b0; m_low = 1'b0;
      m_load_cyc = cyc + 1;
      m_deadline = cyc + 1 + ACK;
    end
    pair = {band_id, bcid};
    req = data_ready && (band_id != 8'hFF) && (pair != m_last);
    if (req) begin
      m_last = pair;
      if (m_q.size() < DEPTH) m_q.push_back(pair);
      else begin
        if (m_drops < 65535) m_drops++;
        m_ovf = 1'b1;
      end
    end
  endtask

  // Compare process: advance the model on each edge and check all outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      chk("load_out", load_out, e_load);
      chk("band_id_out", band_id_out, e_band);
      chk("bcid_out", bcid_out, e_bcid);
      chk("fifo_count", fifo_count, m_q.size());
      chk("drop_count", drop_count, m_drops);
      chk("overflow", overflow, m_ovf);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, input logic [11:0] c);
    data_ready = 1'b1; band_id = b; bcid = c;
    tick();
    data_ready = 1'b0; band_id = 8'hFF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_load_out", load_out, 32'd0);
    chk("rst_bcid_out", bcid_out, 32'd0);
    chk("rst_band_id_out", band_id_out, 32'd0);
    chk("rst_fifo_count", fifo_count, 32'd0);
    chk("rst_drop_count", drop_count, 32'd0);
    chk("rst_overflow", overflow, 32'd0);
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_load(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (load_out === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL load_wait: no load_out within %0d cycles", budget);
    end
  endtask

  initial begin
    int t1, t2, loads, prev, low_left, mode;
    tick(2);
    do_reset();

    // single entry goes out at the next slot with its band/BCID
    gen_ready = 1'b1;
    push(8'h12, 12'h345);
    wait_load(6, t1);
    chk("s1_band", band_id_out, 32'h12);
    chk("s1_bcid", bcid_out, 32'h345);
    tick();
    chk("s1_count", fifo_count, 32'd0);

    // duplicate suppression
    gen_ready = 1'b0;
    push(8'h05, 12'h010);
    push(8'h05, 12'h010);
    push(8'h05, 12'h011);
    tick();
    chk("s2_count", fifo_count, 32'd2);
    chk("s2_drops", drop_count, 32'd0);

    // overflow then ordered drain
    do_reset();
    gen_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(i + 1), 12'(12'h100 + i));
    tick();
    chk("s3_count", fifo_count, 32'd8);
    chk("s3_drops", drop_count, 32'd2);
    chk("s3_overflow", overflow, 32'd1);
    loads = 0; prev = -100; low_left = 0;
    for (int i = 0; i < 200 && loads < 8; i++) begin
      if (load_out) begin
        loads++;
        chk("s3_gap_ok", 32'(cyc - prev >= SLOTS), 32'd1);
        prev = cyc;
        low_left = 3;
      end
      gen_ready = (low_left == 0);
      if (low_left > 0) low_left--;
      tick();
    end
    chk("s3_loads", loads, 32'd8);
    gen_ready = 1'b0; tick(3);
    gen_ready = 1'b1; tick(3);
    chk("s3_empty", fifo_count, 32'd0);

    // no-band input is ignored
    gen_ready = 1'b0;
    push(8'hFF, 12'h123);
    tick();
    chk("s4_count", fifo_count, 32'd0);
    chk("s4_drops", drop_count, 32'd2);

    // push coinciding with pop while full is accepted
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i), 12'(i));
    chk("s5_full", fifo_count, 32'd8);
    while ((m_n % SLOTS) != SLOTS - 1) tick();
    gen_ready = 1'b1;
    push(8'h50, 12'h001);
    gen_ready = 1'b0;
    chk("s5_load", load_out, 32'd1);
    chk("s5_count", fifo_count, 32'd8);
    chk("s5_drops", drop_count, 32'd2);
    tick(4);

    // acknowledge timeout with gen_ready stuck high
    gen_ready = 1'b1;
    wait_load(20, t1);
    tick();
    wait_load(20, t2);
    chk("s6_gap", t2 - t1, 32'd12);

    // reset during WAIT_DONE with entries queued
    gen_ready = 1'b0;
    tick(3);
    chk("s7_count", fifo_count, 32'd6);
    do_reset();
    gen_ready = 1'b1;
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_out) loads++;
      tick();
    end
    chk("s7_no_load", loads, 32'd0);

    // randomized traffic under varying serializer behaviour
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      int b;
      mode = (i / 250) % 4;
      data_ready = ($urandom_range(0, 1) == 1);
      b = $urandom_range(0, 4);
      band_id = (b == 4) ? 8'hFF : 8'(b);
      bcid = 12'($urandom_range(0, 3));
      case (mode)
        0: gen_ready = ($urandom_range(0, 3) != 0);
        1: gen_ready = 1'b1;
        2: begin
          if (load_out) low_left = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
          gen_ready = (low_left == 0);
          if (low_left > 0) low_left--;
        end
        default: gen_ready = 1'b0;
      endcase
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    data_ready = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
